bcd_scan_decoder: RTL
=====================

BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

Interface
REQ-001 SHALL provide parameter DIGITS, default 4: number of BCD digits scanned, range 1..8.
REQ-002 SHALL provide parameter OUT_W, default 10: one-hot output width, range 2..16.
REQ-003 SHALL provide parameter SCAN_DIV, default 1000: clocks per digit slot, range 1..65535.
REQ-004 SHALL provide parameter BLANK_LZ, default 0: 1 enables leading-zero blanking.
REQ-005 SHALL have port iCLK, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port iRST, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port iEN, input, 1: scan enable.
REQ-008 SHALL have port iLOAD, input, 1: capture iBCD into the shadow register.
REQ-009 SHALL have port iBCD, input, 4*DIGITS: packed codes; digit d at [4d+3:4d]; digit DIGITS-1 is most significant.
REQ-010 SHALL have port oSEL, output, DIGITS: one-hot select of the digit currently shown.
REQ-011 SHALL have port oOUT, output, OUT_W: one-hot decode of the shown digit.
REQ-012 SHALL have port oERR, output, 1: shown digit code is invalid (code >= OUT_W).
REQ-013 SHALL have port oFRAME, output, 1: one-cycle pulse when the scan wraps to digit 0.

Function
REQ-014 iLOAD=1 at an edge SHALL copy iBCD into the shadow register at that edge; iLOAD=0 SHALL leave the shadow register unchanged.
REQ-015 A prescaler SHALL count 0..SCAN_DIV-1 while iEN=1; the edge at count SCAN_DIV-1 SHALL be a tick and SHALL return the count to 0.
REQ-016 On each tick, the digit index SHALL advance by 1, wrapping DIGITS-1 -> 0; with DIGITS=1 the index SHALL stay at 0 and every tick is a wrap.
REQ-017 iEN=0 SHALL hold the prescaler and digit index, and SHALL register oSEL=0, oOUT=0, oERR=0 and oFRAME=0 (blank).
REQ-018 All outputs SHALL be registered with exactly 1 cycle latency: at each edge they reflect the shadow register, index and iEN values that held before that edge.
REQ-019 For code c < OUT_W, oOUT SHALL be 1<<c and oERR=0.
REQ-020 For code c >= OUT_W, oOUT SHALL be all ones and oERR=1.
REQ-021 oSEL SHALL be 1<<index whenever iEN=1.
REQ-022 With BLANK_LZ=1, a digit SHALL be blanked (oOUT=0, oERR=0, oSEL still driven) when it and every more-significant digit equal 0.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 An invalid code SHALL count as nonzero for the blanking rule.
REQ-025 oFRAME SHALL be 1 for exactly the cycle after the tick that wraps the index to 0, and 0 otherwise.
REQ-026 When iLOAD and a tick occur at the same edge, both SHALL take effect; the output registered at the next edge SHALL use the new shadow value and the new index.
REQ-027 Changes to iBCD without iLOAD SHALL have no effect on any output.

Reset
REQ-028 iRST=1 at an edge SHALL clear the shadow register to 0, the prescaler to 0 and the index to 0.
REQ-029 iRST=1 at an edge SHALL register oSEL=0, oOUT=0, oERR=0 and oFRAME=0.
REQ-030 iRST SHALL take priority over iLOAD and iEN, including mid-scan and mid-slot.
REQ-031 On the first edge after iRST falls with iEN=1, the outputs SHALL show digit 0: oSEL=1 and oOUT=1.

Structure
REQ-032 Package bcd_scan_pkg SHALL hold the default parameter constants and the BCD code width of 4.
REQ-033 Decoding SHALL be done in one combinational sub-module, onehot_dec (parameter OUT_W: code in, one-hot out, invalid flag out), instantiated once on the selected digit.
REQ-034 Prescaler and index widths SHALL be clog2-derived from SCAN_DIV and DIGITS, minimum 1 bit.
REQ-035 Expected size: 120-400 lines of RTL.

Verification (DIGITS=4, SCAN_DIV=4, OUT_W=10 unless stated)
REQ-036 Reset then iEN=1, load 16'h1234 -> oSEL cycles 0001,0010,0100,1000 every 4 clocks; oOUT = 0x010, 0x008, 0x004, 0x002; oFRAME pulses once per 16 clocks.
REQ-037 Load 16'h00A5 -> digit 1 shows oOUT=0x3FF with oERR=1; digit 0 shows 0x020 with oERR=0.
REQ-038 BLANK_LZ=1, load 16'h0070 -> digits 3 and 2 show oOUT=0; digit 1 shows 0x080; digit 0 shows 0x001; load 16'h0000 -> only digit 0 shows 0x001.
REQ-039 iEN low for 10 clocks mid-slot, then high -> outputs are 0 while low; the scan resumes on the same digit with the remaining slot count unchanged.
REQ-040 iRST pulsed while the index is 2 -> the next edge gives all outputs 0; after release oSEL=0001 and oOUT=0x001 (shadow cleared).
REQ-041 iLOAD coincident with a tick -> the new digit appears with the new shadow value one cycle later; DIGITS=1 -> oFRAME pulses every tick.

Source files
------------

// File: rtl/bcd_scan_pkg.sv
// Shared constants for the multiplexed BCD scan decoder: default parameters,
// BCD code width and a width helper for counters.
package bcd_scan_pkg;

    localparam int BCD_W        = 4;

    localparam int DEF_DIGITS   = 4;
    localparam int DEF_OUT_W    = 10;
    localparam int DEF_SCAN_DIV = 1000;
    localparam int DEF_BLANK_LZ = 0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational code-to-one-hot decoder; codes at or above OUT_W are flagged
// invalid and drive every output bit high.
module onehot_dec
    import bcd_scan_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [BCD_W-1:0] code,
    output logic [OUT_W-1:0] onehot,
    output logic             invalid
);

    localparam logic [BCD_W:0] LIMIT = (BCD_W + 1)'(OUT_W);

    assign invalid = ({1'b0, code} >= LIMIT);

    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (code == BCD_W'(i));
        end
        if (invalid) begin
            onehot = '1;
        end
    end

endmodule

// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed BCD display driver: a shadow register of DIGITS codes is
// scanned one digit per SCAN_DIV clocks and the shown digit decoded to one-hot.
module bcd_scan_decoder
    import bcd_scan_pkg::*;
#(
    parameter int DIGITS   = DEF_DIGITS,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int BLANK_LZ = DEF_BLANK_LZ
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iEN,
    input  logic                    iLOAD,
    input  logic [BCD_W*DIGITS-1:0] iBCD,
    output logic [DIGITS-1:0]       oSEL,
    output logic [OUT_W-1:0]        oOUT,
    output logic                    oERR,
    output logic                    oFRAME
);

    localparam int PW = clog2_min1(SCAN_DIV);
    localparam int IW = clog2_min1(DIGITS);

    logic [BCD_W*DIGITS-1:0] shadow;
    logic [PW-1:0]           prescale;
    logic [IW-1:0]           index;

    logic                    tick;
    logic                    wrap;
    logic [BCD_W-1:0]        cur_code;
    logic [DIGITS-1:0]       sel_next;
    logic                    upper_zero;
    logic                    blank;
    logic [OUT_W-1:0]        dec_out;
    logic                    dec_err;

    assign tick = iEN && (prescale == PW'(SCAN_DIV - 1));
    assign wrap = (index == IW'(DIGITS - 1));

    // Digit mux and select one-hot share the same index comparison.
    always_comb begin
        cur_code = '0;
        sel_next = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (index == IW'(d)) begin
                cur_code    = shadow[BCD_W*d +: BCD_W];
                sel_next[d] = 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and all more-significant codes are 0;
    // invalid codes are nonzero and therefore stop the blanking.
    always_comb begin
        upper_zero = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if ((IW'(d) >= index) && (shadow[BCD_W*d +: BCD_W] != '0)) begin
                upper_zero = 1'b0;
            end
        end
        blank = (BLANK_LZ != 0) && (index != '0) && upper_zero;
    end

    onehot_dec #(
        .OUT_W (OUT_W)
    ) u_dec (
        .code    (cur_code),
        .onehot  (dec_out),
        .invalid (dec_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            shadow   <= '0;
            prescale <= '0;
            index    <= '0;
        end else begin
            if (iLOAD) begin
                shadow <= iBCD;
            end
            if (iEN) begin
                if (tick) begin
                    prescale <= '0;
                    index    <= wrap ? '0 : index + 1'b1;
                end else begin
                    prescale <= prescale + 1'b1;
                end
            end
        end
    end

    // Outputs reflect the state held before the edge, giving one cycle of latency.
    always_ff @(posedge iCLK) begin
        if (iRST || !iEN) begin
            oSEL   <= '0;
            oOUT   <= '0;
            oERR   <= 1'b0;
            oFRAME <= 1'b0;
        end else begin
            oSEL   <= sel_next;
            oOUT   <= blank ? '0 : dec_out;
            oERR   <= blank ? 1'b0 : dec_err;
            oFRAME <= tick && wrap;
        end
    end

endmodule
